// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: debounced up/down buttons plus an optional 1 Hz-style
// auto-count drive a single registered BCD digit (A = MSB .. D = LSB).
// carry/borrow pulse for one cycle on the 9->0 / 0->9 wraps so that a
// further digit can be cascaded.
module bcd_digit_counter #(
    parameter int DB_CYCLES   = 120000,
    parameter int TICK_CYCLES = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic auto_en,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic carry,
    output logic borrow
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    // index 0 = up button, index 1 = down button
    logic [1:0]      btn_raw;
    logic [1:0]      btn_s1;
    logic [1:0]      btn_s2;
    logic [1:0]      stable;
    logic [1:0]      stable_q;
    logic [DB_W-1:0] db_cnt [2];

    logic            auto_s1;
    logic            auto_s2;
    logic [TK_W-1:0] pre;
    logic            tick;

    logic            up_event;
    logic            dn_event;
    logic            inc;
    logic            dec;
    logic [3:0]      digit;

    assign btn_raw = {btn_dn, btn_up};

    // Two-flop synchronizers for both buttons and the auto-count enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            auto_s1 <= auto_en;
            auto_s2 <= auto_s1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable;
        end
    end

    assign up_event = stable[0] & ~stable_q[0];
    assign dn_event = stable[1] & ~stable_q[1];

    // Auto-count prescaler; held at zero while the synced enable is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (!auto_s2) begin
            pre <= '0;
        end else if (pre == TK_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = auto_s2 && (pre == TK_LAST);
    assign inc  = up_event | tick;
    assign dec  = dn_event;

    // BCD digit with registered single-cycle carry/borrow on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (inc && !dec) begin
                if (digit == 4'd9) begin
                    digit <= '0;
                    carry <= 1'b1;
                end else begin
                    digit <= digit + 4'd1;
                end
            end else if (dec && !inc) begin
                if (digit == 4'd0) begin
                    digit  <= 4'd9;
                    borrow <= 1'b1;
                end else begin
                    digit <= digit - 4'd1;
                end
            end
        end
    end

    assign A = digit[3];
    assign B = digit[2];
    assign C = digit[1];
    assign D = digit[0];

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench for bcd_digit_counter (DB_CYCLES=4, TICK_CYCLES=8).
// Stimulus pushes the expected output change (cycle, digit, carry, borrow);
// the monitor pops an entry on every observed output change.
module tb_bcd_digit_counter;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_dn;
    logic auto_en;
    logic A, B, C, D;
    logic carry;
    logic borrow;

    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  d;
        logic        c;
        logic        b;
    } exp_t;

    exp_t q[$];

    bcd_digit_counter #(
        .DB_CYCLES  (4),
        .TICK_CYCLES(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .auto_en(auto_en),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .carry  (carry),
        .borrow (borrow)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int unsigned c, input logic [3:0] d,
                             input logic cy, input logic bw);
        exp_t e;
        e.cyc = c;
        e.d   = d;
        e.c   = cy;
        e.b   = bw;
        q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        logic [5:0] cur;
        logic [5:0] prev;
        bit first;
        exp_t e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {A, B, C, D, carry, borrow};
            if (first || cur !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got d=%0d c=%0b b=%0b, want no change",
                             cyc, cur[5:2], cur[1], cur[0]);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || cur[5:2] !== e.d || cur[1] !== e.c || cur[0] !== e.b) begin
                        bad++;
                        $display("FAIL event got d=%0d c=%0b b=%0b at cyc %0d, want d=%0d c=%0b b=%0b at cyc %0d",
                                 cur[5:2], cur[1], cur[0], cyc, e.d, e.c, e.b, e.cyc);
                    end
                end
            end
            while (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_change cyc=%0d got d=%0d c=%0b b=%0b, want d=%0d c=%0b b=%0b at cyc %0d",
                         cyc, cur[5:2], cur[1], cur[0], e.d, e.c, e.b, e.cyc);
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean debounced press; d/cy are the hand-computed result
    task automatic press_up(input logic [3:0] d, input logic cy);
        @(negedge clk);
        btn_up = 1'b1;
        expect_at(cyc + 7, d, cy, 1'b0);
        if (cy) expect_at(cyc + 8, d, 1'b0, 1'b0);
        idle(10);
        btn_up = 1'b0;
        idle(10);
    endtask

    task automatic press_dn(input logic [3:0] d, input logic bw);
        @(negedge clk);
        btn_dn = 1'b1;
        expect_at(cyc + 7, d, 1'b0, bw);
        if (bw) expect_at(cyc + 8, d, 1'b0, 1'b0);
        idle(10);
        btn_dn = 1'b0;
        idle(10);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        expect_at(cyc + 1, 4'd0, 1'b0, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    initial begin : stim
        int unsigned x;
        logic [4:0] bounce;
        rst     = 1'b1;
        btn_up  = 1'b0;
        btn_dn  = 1'b0;
        auto_en = 1'b0;
        expect_at(1, 4'd0, 1'b0, 1'b0);
        idle(3);
        rst = 1'b0;
        idle(2);

        // clean hold: 0001 on edge 7, nothing more while held
        @(negedge clk);
        btn_up = 1'b1;
        expect_at(cyc + 7, 4'd1, 1'b0, 1'b0);
        idle(14);
        btn_up = 1'b0;
        idle(10);

        // bounce 1,0,1,1,0 then steady 1
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            btn_up = bounce[i];
        end
        @(negedge clk);
        btn_up = 1'b1;
        expect_at(cyc + 7, 4'd2, 1'b0, 1'b0);
        idle(12);
        btn_up = 1'b0;
        idle(10);

        // 3-cycle glitch is never accepted
        @(negedge clk);
        btn_up = 1'b1;
        idle(3);
        btn_up = 1'b0;
        idle(12);

        // ten presses from 0: 1..9 then 0 with carry
        pulse_reset();
        for (int i = 1; i <= 10; i++) begin
            press_up(4'((i == 10) ? 0 : i), i == 10);
        end

        // down from 0 wraps to 9 with borrow, then 8 without
        press_dn(4'd9, 1'b1);
        press_dn(4'd8, 1'b0);
        press_dn(4'd7, 1'b0);
        press_dn(4'd6, 1'b0);
        press_dn(4'd5, 1'b0);

        // simultaneous up/down at 5: no change at all
        @(negedge clk);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        idle(12);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        idle(10);

        // auto-count from 0: edges 10, 18, 26, then freeze
        pulse_reset();
        @(negedge clk);
        auto_en = 1'b1;
        expect_at(cyc + 10, 4'd1, 1'b0, 1'b0);
        expect_at(cyc + 18, 4'd2, 1'b0, 1'b0);
        expect_at(cyc + 26, 4'd3, 1'b0, 1'b0);
        idle(26);
        auto_en = 1'b0;
        idle(24);

        // climb to 7, then reset mid-debounce and mid-tick
        press_up(4'd4, 1'b0);
        press_up(4'd5, 1'b0);
        press_up(4'd6, 1'b0);
        press_up(4'd7, 1'b0);
        @(negedge clk);
        auto_en = 1'b1;
        x = cyc;
        @(negedge clk);
        btn_up = 1'b1;
        while (cyc < x + 5) @(negedge clk);
        rst = 1'b1;
        auto_en = 1'b0;
        expect_at(cyc + 1, 4'd0, 1'b0, 1'b0);
        idle(3);
        rst = 1'b0;
        expect_at(cyc + 7, 4'd1, 1'b0, 1'b0);
        idle(12);
        btn_up = 1'b0;
        idle(12);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
- Upstream source stage for the single-digit 7-segment decoder.
- Turns two raw push buttons (up/down) and an auto-count enable into a registered BCD digit 0-9 on A,B,C,D, with A as the MSB.
- Output feeds the decoder's A,B,C,D inputs directly. Carry and borrow pulses allow a later digit to be cascaded.

Parameters:
- DB_CYCLES, 120000, consecutive stable samples needed to accept a button change (10 ms at 12 MHz); minimum 2.
- TICK_CYCLES, 12000000, auto-count period in clocks (1 s at 12 MHz); minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_up  in  1  raw, asynchronous, bouncy, active-high increment button
- btn_dn  in  1  raw, asynchronous, bouncy, active-high decrement button
- auto_en  in  1  level; when high, the digit increments once per TICK_CYCLES
- A  out  1  BCD bit 3 (MSB)
- B  out  1  BCD bit 2
- C  out  1  BCD bit 1
- D  out  1  BCD bit 0 (LSB)
- carry  out  1  one-cycle pulse on 9->0 wrap
- borrow  out  1  one-cycle pulse on 0->9 wrap

Behaviour:
- Reset: asynchronous, active-high. On assertion, all flops clear immediately:
  - digit = 0, so A,B,C,D = 0000
  - carry = 0, borrow = 0
  - synchronizers, debounced states, debounce counters, prescaler and edge registers all 0
- Reset mid-press: after release of reset, a button still held reads as a fresh press. It counts after the full debounce delay.
- Synchronizer: each button passes through a 2-flop synchronizer (s1 -> s2). auto_en is also 2-flop synchronized.
- Debounce (one instance per button):
  - Holds a stable bit and a counter of width clog2(DB_CYCLES).
  - If s2 == stable: counter cleared.
  - Else, if counter == DB_CYCLES-1: stable <= s2 and counter cleared.
  - Else: counter increments.
  - Any bounce back to the stable value restarts the count. A pulse shorter than DB_CYCLES cycles is therefore never accepted.
- Edge detect: a press event is a 1-cycle pulse on the rising edge of stable (stable & ~stable_q). Release produces no event.
- Prescaler:
  - While synced auto_en = 0, the prescaler is held at 0.
  - While 1, it counts 0..TICK_CYCLES-1. Reaching TICK_CYCLES-1 emits a 1-cycle tick and wraps to 0.
- Counter update, evaluated on each clock with inc = up_event | tick and dec = dn_event:
  - inc & ~dec: digit = (digit == 9) ? 0 : digit+1; carry = 1 on the 9->0 transition.
  - dec & ~inc: digit = (digit == 0) ? 9 : digit-1; borrow = 1 on the 0->9 transition.
  - inc & dec (simultaneous): digit unchanged, no carry/borrow.
  - Neither: digit unchanged.
- carry and borrow are registered, asserted in the same cycle as the new digit value, and return to 0 on the next clock.
- Range: the digit is always 0..9. Values 10-15 are never driven, so the decoder's blank case is unreachable from this block.
- Latency, counted in rising edges after btn first samples high with a clean input:
  - s2 high after 2 edges.
  - stable high after 2+DB_CYCLES edges.
  - digit updated after DB_CYCLES+3 edges.
- First auto increment: TICK_CYCLES+2 edges after auto_en rises. Subsequent increments every TICK_CYCLES.
- Holding a button does not auto-repeat.

Test Plan (DB_CYCLES=4, TICK_CYCLES=8):
- Reset, then hold btn_up clean high -> ABCD stays 0000 for 6 edges and becomes 0001 on edge 7; no further change while held.
- btn_up bounce 1,0,1,1,0 then steady 1 -> exactly one increment, taking effect 7 edges after the steady 1 begins; a 3-cycle glitch alone gives no change.
- Ten debounced btn_up presses from 0 -> digit steps 1..9 then 0; carry high for exactly the one cycle the digit shows 0000, otherwise 0.
- One debounced btn_dn press from 0 -> digit 1001 (9) with a one-cycle borrow pulse; a second press -> 1000 with no borrow.
- btn_up and btn_dn debounced in the same cycle at digit 5 -> digit stays 0101, carry = borrow = 0.
- auto_en high for 26 cycles from 0 -> increments on edges 10, 18 and 26; drop auto_en -> prescaler clears and the count freezes.
- Assert rst mid-debounce and mid-tick at digit 7 -> outputs 0000 immediately, with no carry or borrow; a button held through reset counts 7 edges after rst falls.
